// File: rtl/ps_inspect_pkg.sv
// Shared constants and width helpers for the PS clock prescaler / monitor pair.
package ps_inspect_pkg;

   localparam int unsigned NUM_PL_CLK       = 4;
   localparam int unsigned DEF_WINDOW       = 1024;
   localparam int unsigned DEF_STUCK_CYCLES = 256;

   // Counter wide enough to hold the full count value itself (e.g. WINDOW edges, or a prescale ratio).
   function automatic int unsigned cnt_width(input int unsigned window);
      return 32'($clog2(window)) + 32'd1;
   endfunction

   function automatic int unsigned per_width(input int unsigned stuck_cycles);
      return 32'($clog2(stuck_cycles)) + 32'd1;
   endfunction

endpackage

// File: rtl/ps_clk_edge_meas.sv
// One divided-clock channel: synchronizer, rise detect, window edge count, period and stuck detection.
// Optional period min/max tracking under PS_CLK_MONITOR_MINMAX_EN.
module ps_clk_edge_meas
   import ps_inspect_pkg::*;
#(
   parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned CNT_W        = cnt_width(DEF_WINDOW),
   parameter int unsigned PER_W        = per_width(STUCK_CYCLES)
) (
   input  logic             ila_clk,
   input  logic             pl_resetn,
   input  logic             div_clk,
   input  logic             win_last,
`ifdef PS_CLK_MONITOR_MINMAX_EN
   input  logic             min_max_clr,
   output logic [PER_W-1:0] period_min,
   output logic [PER_W-1:0] period_max,
`endif
   output logic             rise_c,
   output logic [CNT_W-1:0] edge_cnt,
   output logic [PER_W-1:0] period,
   output logic             period_vld,
   output logic             stuck
);

   localparam logic [PER_W-1:0] PER_SAT   = PER_W'(STUCK_CYCLES);
   localparam logic [PER_W-1:0] PER_STUCK = PER_W'(STUCK_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   seen_rise_q;
   logic [PER_W-1:0]       per_cnt_q;
   logic [PER_W-1:0]       per_meas_c;
   logic                   meas_c;

   assign rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign meas_c     = rise_c & seen_rise_q;
   assign per_meas_c = (per_cnt_q == PER_SAT) ? PER_SAT : per_cnt_q + PER_W'(1);

   // Input is async data: sample it through the synchronizer chain, then one history flop.
   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         per_cnt_q   <= '0;
         seen_rise_q <= 1'b0;
         period      <= '0;
         period_vld  <= 1'b0;
         stuck       <= 1'b0;
         edge_cnt    <= '0;
      end else begin
         if (rise_c)
            per_cnt_q <= '0;
         else if (per_cnt_q != PER_SAT)
            per_cnt_q <= per_cnt_q + PER_W'(1);

         // First rise after reset only arms the period measurement.
         if (rise_c)
            seen_rise_q <= 1'b1;
         if (meas_c) begin
            period     <= per_meas_c;
            period_vld <= 1'b1;
         end

         if (rise_c)
            stuck <= 1'b0;
         else if (per_cnt_q == PER_STUCK)
            stuck <= 1'b1;

         if (win_last)
            edge_cnt <= '0;
         else if (rise_c && (edge_cnt != '1))
            edge_cnt <= edge_cnt + CNT_W'(1);
      end
   end

`ifdef PS_CLK_MONITOR_MINMAX_EN
   logic mm_first_q;

   // A measurement coinciding with a clear is loaded as the first sample.
   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         period_min <= '0;
         period_max <= '0;
         mm_first_q <= 1'b1;
      end else if (meas_c && (min_max_clr || mm_first_q)) begin
         period_min <= per_meas_c;
         period_max <= per_meas_c;
         mm_first_q <= 1'b0;
      end else if (meas_c) begin
         if (per_meas_c < period_min)
            period_min <= per_meas_c;
         if (per_meas_c > period_max)
            period_max <= per_meas_c;
      end else if (min_max_clr) begin
         period_min <= '1;
         period_max <= '0;
         mm_first_q <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/ps_clk_monitor.sv
// Measures frequency, period and stuck status of the four divided PL clocks in the ila_clk domain.
// Define PS_CLK_MONITOR_MINMAX_EN to add per-channel period min/max tracking.
module ps_clk_monitor
   import ps_inspect_pkg::*;
#(
   parameter  int unsigned WINDOW       = DEF_WINDOW,
   parameter  int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES,
   parameter  int unsigned SYNC_STAGES  = 2,
   localparam int unsigned CNT_W        = cnt_width(WINDOW),
   localparam int unsigned PER_W        = per_width(STUCK_CYCLES)
) (
   input  logic                        ila_clk,
   input  logic                        pl_resetn,
   input  logic                        div_pl_clk_0,
   input  logic                        div_pl_clk_1,
   input  logic                        div_pl_clk_2,
   input  logic                        div_pl_clk_3,
`ifdef PS_CLK_MONITOR_MINMAX_EN
   input  logic                        min_max_clr,
   output logic [NUM_PL_CLK*PER_W-1:0] period_min,
   output logic [NUM_PL_CLK*PER_W-1:0] period_max,
`endif
   output logic                        meas_valid,
   output logic [NUM_PL_CLK*CNT_W-1:0] freq_cnt,
   output logic [NUM_PL_CLK*PER_W-1:0] period,
   output logic [NUM_PL_CLK-1:0]       period_vld,
   output logic [NUM_PL_CLK-1:0]       stuck
);

   localparam int unsigned WIN_W = CNT_W - 1;

   logic [NUM_PL_CLK-1:0] div_clk_c;
   logic [NUM_PL_CLK-1:0] ch_rise_c;
   logic [CNT_W-1:0]      ch_edge_cnt [NUM_PL_CLK];
   logic [WIN_W-1:0]      win_cnt_q;
   logic                  win_last_c;

   assign div_clk_c  = {div_pl_clk_3, div_pl_clk_2, div_pl_clk_1, div_pl_clk_0};
   assign win_last_c = (win_cnt_q == WIN_W'(WINDOW - 1));

   for (genvar i = 0; i < NUM_PL_CLK; i++) begin : g_ch
      ps_clk_edge_meas #(
         .STUCK_CYCLES (STUCK_CYCLES),
         .SYNC_STAGES  (SYNC_STAGES),
         .CNT_W        (CNT_W),
         .PER_W        (PER_W)
      ) u_meas (
         .ila_clk     (ila_clk),
         .pl_resetn   (pl_resetn),
         .div_clk     (div_clk_c[i]),
         .win_last    (win_last_c),
`ifdef PS_CLK_MONITOR_MINMAX_EN
         .min_max_clr (min_max_clr),
         .period_min  (period_min[i*PER_W +: PER_W]),
         .period_max  (period_max[i*PER_W +: PER_W]),
`endif
         .rise_c      (ch_rise_c[i]),
         .edge_cnt    (ch_edge_cnt[i]),
         .period      (period[i*PER_W +: PER_W]),
         .period_vld  (period_vld[i]),
         .stuck       (stuck[i])
      );
   end

   // Window timebase; a rise on the closing cycle is folded into that window's result.
   always_ff @(posedge ila_clk or negedge pl_resetn) begin
      if (!pl_resetn) begin
         win_cnt_q  <= '0;
         meas_valid <= 1'b0;
         freq_cnt   <= '0;
      end else begin
         win_cnt_q  <= win_cnt_q + WIN_W'(1);
         meas_valid <= win_last_c;
         if (win_last_c) begin
            for (int i = 0; i < NUM_PL_CLK; i++)
               freq_cnt[i*CNT_W +: CNT_W] <= ch_edge_cnt[i] + CNT_W'(ch_rise_c[i]);
         end
      end
   end

endmodule

// File: tb/tb_ps_clk_monitor.sv
// Randomized scoreboard bench for ps_clk_monitor with a rise-time based reference model.
module tb_ps_clk_monitor;

   localparam int unsigned WINDOW = 64;
   localparam int unsigned STUCK  = 256;
   localparam int unsigned SYNC   = 2;
   localparam int unsigned NCH    = 4;
   localparam int unsigned CNT_W  = 7;
   localparam int unsigned PER_W  = 9;
   localparam int          LAT    = 3;
   localparam int          MAXT   = 1400;

   typedef struct {
      int                     cyc;
      logic [NCH*CNT_W-1:0]   f;
   } meas_t;

   logic                   ila_clk   = 1'b0;
   logic                   pl_resetn = 1'b1;
   logic [NCH-1:0]         din       = '0;
   logic                   meas_valid;
   logic [NCH*CNT_W-1:0]   freq_cnt;
   logic [NCH*PER_W-1:0]   period;
   logic [NCH-1:0]         period_vld;
   logic [NCH-1:0]         stuck;
`ifdef PS_CLK_MONITOR_MINMAX_EN
   logic                   min_max_clr = 1'b0;
   logic [NCH*PER_W-1:0]   period_min;
   logic [NCH*PER_W-1:0]   period_max;
   bit                     clr_at [MAXT+8];
   int                     exp_min [NCH];
   int                     exp_max [NCH];
   bit                     mm_first [NCH];
`endif

   int    n_chk  = 0;
   int    n_fail = 0;
   int    t      = 0;
   bit    checking = 1'b0;

   bit    rise_at [NCH][MAXT+8];
   int    last_rise [NCH];
   bit    seen [NCH];
   int    exp_period [NCH];
   bit    exp_vld [NCH];
   bit    exp_stuck [NCH];
   int    win_edges [NCH];
   bit    exp_mv;
   meas_t exp_q [$];
   meas_t mon_m;

   always #5 ila_clk = ~ila_clk;

   ps_clk_monitor #(
      .WINDOW       (WINDOW),
      .STUCK_CYCLES (STUCK),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .ila_clk      (ila_clk),
      .pl_resetn    (pl_resetn),
      .div_pl_clk_0 (din[0]),
      .div_pl_clk_1 (din[1]),
      .div_pl_clk_2 (din[2]),
      .div_pl_clk_3 (din[3]),
`ifdef PS_CLK_MONITOR_MINMAX_EN
      .min_max_clr  (min_max_clr),
      .period_min   (period_min),
      .period_max   (period_max),
`endif
      .meas_valid   (meas_valid),
      .freq_cnt     (freq_cnt),
      .period       (period),
      .period_vld   (period_vld),
      .stuck        (stuck)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_meas_valid"}, 64'(meas_valid), 64'd0);
      chk({tag, "_freq_cnt"},   64'(freq_cnt),   64'd0);
      chk({tag, "_period"},     64'(period),     64'd0);
      chk({tag, "_period_vld"}, 64'(period_vld), 64'd0);
      chk({tag, "_stuck"},      64'(stuck),      64'd0);
`ifdef PS_CLK_MONITOR_MINMAX_EN
      chk({tag, "_period_min"}, 64'(period_min), 64'd0);
      chk({tag, "_period_max"}, 64'(period_max), 64'd0);
`endif
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < MAXT + 8; k++) rise_at[c][k] = 1'b0;
         last_rise[c]  = 0;
         seen[c]       = 1'b0;
         exp_period[c] = 0;
         exp_vld[c]    = 1'b0;
         exp_stuck[c]  = 1'b0;
         win_edges[c]  = 0;
`ifdef PS_CLK_MONITOR_MINMAX_EN
         exp_min[c]  = 0;
         exp_max[c]  = 0;
         mm_first[c] = 1'b1;
`endif
      end
`ifdef PS_CLK_MONITOR_MINMAX_EN
      for (int k = 0; k < MAXT + 8; k++) clr_at[k] = 1'b0;
`endif
      exp_mv = 1'b0;
      exp_q.delete();
   endtask

   // Expected outputs after clock edge tc, derived from when each synchronized rise lands.
   task automatic model_step(input int tc);
      meas_t m;
      int    p;
      for (int c = 0; c < NCH; c++) begin
         if (rise_at[c][tc]) begin
            if (seen[c]) begin
               p = tc - last_rise[c];
               if (p > int'(STUCK)) p = int'(STUCK);
               exp_period[c] = p;
               exp_vld[c]    = 1'b1;
`ifdef PS_CLK_MONITOR_MINMAX_EN
               if (clr_at[tc] || mm_first[c]) begin
                  exp_min[c] = p; exp_max[c] = p; mm_first[c] = 1'b0;
               end else begin
                  if (p < exp_min[c]) exp_min[c] = p;
                  if (p > exp_max[c]) exp_max[c] = p;
               end
`endif
            end
`ifdef PS_CLK_MONITOR_MINMAX_EN
            else if (clr_at[tc]) begin
               exp_min[c] = (1 << PER_W) - 1; exp_max[c] = 0; mm_first[c] = 1'b1;
            end
`endif
            seen[c]      = 1'b1;
            last_rise[c] = tc;
            exp_stuck[c] = 1'b0;
            win_edges[c]++;
         end else begin
            if (tc - last_rise[c] >= int'(STUCK)) exp_stuck[c] = 1'b1;
`ifdef PS_CLK_MONITOR_MINMAX_EN
            if (clr_at[tc]) begin
               exp_min[c] = (1 << PER_W) - 1; exp_max[c] = 0; mm_first[c] = 1'b1;
            end
`endif
         end
      end
      exp_mv = (tc % int'(WINDOW)) == 0;
      if (exp_mv) begin
         m.cyc = tc;
         m.f   = '0;
         for (int c = 0; c < NCH; c++) begin
            m.f[c*CNT_W +: CNT_W] = CNT_W'(win_edges[c]);
            win_edges[c] = 0;
         end
         exp_q.push_back(m);
      end
   endtask

   function automatic int next_half(input int mode, input int ch, input int idx);
      case (mode)
         0: return 8;
         1: begin
            case (ch)
               0: return 4;
               1: return 6;
               2: return 10;
               default: return 150;
            endcase
         end
         3: return ((idx % 4) < 2) ? 5 : 7;
         default: begin
            if (ch == 2) return 100000;
            if ($urandom_range(15) == 0) return int'($urandom_range(320, 200));
            return int'($urandom_range(24, 1));
         end
      endcase
   endfunction

   task automatic run(input int mode, input int ncyc, input int rst_at);
      int nxt [NCH];
      int tog [NCH];
      pl_resetn = 1'b0;
      din       = '0;
      checking  = 1'b0;
      t         = 0;
`ifdef PS_CLK_MONITOR_MINMAX_EN
      min_max_clr = 1'b0;
`endif
      model_reset();
      repeat (3) @(posedge ila_clk);
      #1;
      chk_all_zero("reset");
      for (int c = 0; c < NCH; c++) begin
         tog[c] = 0;
         nxt[c] = int'($urandom_range(16, 1));
      end
      if (mode == 0) nxt[0] = 13;
      if (mode == 2) nxt[2] = 400;
      @(posedge ila_clk);
      #1;
      pl_resetn = 1'b1;
      checking  = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge ila_clk);
         #1;
         t = k;
         model_step(k);
         if (k == rst_at) break;
         for (int c = 0; c < NCH; c++) begin
            if (k == nxt[c]) begin
               din[c] = ~din[c];
               if (din[c]) rise_at[c][k + LAT] = 1'b1;
               nxt[c] = k + next_half(mode, c, tog[c]);
               tog[c]++;
            end
         end
`ifdef PS_CLK_MONITOR_MINMAX_EN
         min_max_clr = ((mode == 2) && ($urandom_range(63) == 0)) || ((mode == 3) && (k == 200));
         if (min_max_clr) clr_at[k + 1] = 1'b1;
`endif
      end
      if (rst_at > 0) begin
         #2;
         pl_resetn = 1'b0;
         checking  = 1'b0;
         #1;
         chk_all_zero("async_reset");
      end else begin
         @(negedge ila_clk);
         #1;
         checking = 1'b0;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Monitor: per-cycle status checks, and window results popped from the scoreboard on meas_valid.
   always @(negedge ila_clk) begin
      if (checking) begin
         chk("meas_valid", 64'(meas_valid), 64'(exp_mv));
         if (meas_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_meas", 64'(1), 64'(0));
            end else begin
               mon_m = exp_q.pop_front();
               chk("meas_cycle", 64'(t), 64'(mon_m.cyc));
               chk("freq_cnt", 64'(freq_cnt), 64'(mon_m.f));
            end
         end
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("period%0d", c), 64'(period[c*PER_W +: PER_W]), 64'(exp_period[c]));
            chk($sformatf("period_vld%0d", c), 64'(period_vld[c]), 64'(exp_vld[c]));
            chk($sformatf("stuck%0d", c), 64'(stuck[c]), 64'(exp_stuck[c]));
`ifdef PS_CLK_MONITOR_MINMAX_EN
            chk($sformatf("period_min%0d", c), 64'(period_min[c*PER_W +: PER_W]), 64'(exp_min[c]));
            chk($sformatf("period_max%0d", c), 64'(period_max[c*PER_W +: PER_W]), 64'(exp_max[c]));
`endif
         end
      end
   end

   initial begin
      #1;
      run(0, 300, -1);
      run(0, 94, 94);
      run(0, 200, -1);
      run(1, 1300, -1);
      run(2, 1300, -1);
      run(3, 400, -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ps_clk_monitor.md
Name: ps_clk_monitor

Overview:
- Receive-side companion to the PS fabric clock prescaler.
- Samples the four divided PL clocks (div_pl_clk_0..3) as asynchronous data in the ila_clk domain.
- Per channel, measures rising-edge count per fixed window and last full period, and flags stuck clocks.
- Outputs are registered and MARK_DEBUG'd for ILA capture; lets bring-up confirm PS clock frequencies and resets without a scope.

Parameters:
WINDOW, 1024, ila_clk cycles per frequency measurement window; power of two, >=16.
STUCK_CYCLES, 256, ila_clk cycles without a rising edge before stuck is flagged; >=4.
SYNC_STAGES, 2, synchronizer depth per channel; >=2.
(derived localparams) CNT_W = $clog2(WINDOW)+1; PER_W = $clog2(STUCK_CYCLES)+1.

Ports:
ila_clk  input  1  sole clock; all logic in this domain.
pl_resetn  input  1  asynchronous active-low reset; deassertion assumed synchronous to ila_clk upstream.
div_pl_clk_0..div_pl_clk_3  input  1 each  divided clocks, treated as async data, never as clocks.
meas_valid  output  1  one-cycle pulse when freq_cnt updates.
freq_cnt  output  4*CNT_W  rising edges per window; channel i at [i*CNT_W +: CNT_W].
period  output  4*PER_W  ila_clk cycles between the last two rising edges, per channel.
period_vld  output  4  bit i set once channel i has measured one full period.
stuck  output  4  bit i high while channel i has had no rising edge for >= STUCK_CYCLES.

Behaviour:
- Reset (pl_resetn=0, async): every flop clears, including synchronizers and counters.
  - All outputs 0: meas_valid, freq_cnt, period, period_vld, stuck.
  - The window counter restarts at 0 on release.
- Sync: each input passes through SYNC_STAGES flops, then one history flop.
  - rise[i] = sync_out & ~hist.
  - Input-to-rise latency is SYNC_STAGES+1 cycles.
- Window counter: win_cnt runs 0..WINDOW-1 and wraps.
  - Per channel, edge_cnt[i] increments on rise[i] and saturates at all-ones.
  - On the cycle win_cnt==WINDOW-1, freq_cnt[i] <= edge_cnt[i] + rise[i]; a rise in the last cycle counts in the closing window.
  - On that same cycle, edge_cnt[i] <= 0, and meas_valid is asserted for exactly that one cycle, aligned with the freq_cnt update as seen on the next edge.
  - The first meas_valid occurs exactly WINDOW cycles after reset release.
- Period counter per channel: per_cnt[i] increments every cycle and saturates at STUCK_CYCLES.
  - On rise[i], if seen_rise[i]: period[i] <= per_cnt[i]+1 (saturating to STUCK_CYCLES) and period_vld[i] <= 1.
  - On rise[i], always: per_cnt[i] <= 0 and seen_rise[i] <= 1.
  - The first rise after reset only arms the counter and reports no period.
- Stuck: stuck[i] <= (per_cnt[i] == STUCK_CYCLES-1) sets it; the next rise[i] clears it.
  - Set and rise in the same cycle: rise wins and stuck stays 0.
  - Applies to a channel held high or held low, and to a channel with no rise since reset.
- Aliasing: inputs faster than ila_clk/2 alias. That is legal input and the block does no checking.

Optional Feature:
PS_CLK_MONITOR_MINMAX_EN
- Defined:
  - Adds input min_max_clr (1b) and outputs period_min and period_max (4*PER_W each).
  - On each valid period measurement, min and max update.
  - The first measurement after reset or clear loads both.
  - min_max_clr, synchronous, reinitialises min to all-ones and max to 0; a measurement in the same cycle as the clear is loaded as the first.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ps_inspect_pkg holds:
  - NUM_PL_CLK=4
  - default WINDOW and STUCK_CYCLES
  - the CNT_W/PER_W width functions, shared with the prescaler's PRESCALE constant.
- One sub-module, ps_clk_edge_meas, instantiated 4x in a generate loop.
  - Contents: synchronizer, edge detect, edge_cnt, per_cnt, period, stuck, optional min/max.
  - The top holds only win_cnt, meas_valid and the freq_cnt latch.

Test Plan:
- WINDOW=64, all channels toggling with period 16 ila_clk: meas_valid every 64 cycles, first at cycle 64 after reset; freq_cnt=4 each; period=16 and period_vld=1 after the second edge.
- Channel 2 held low, others running: stuck[2]=1 at 256 cycles after its last rise (or after reset); freq_cnt for channel 2 =0; then toggle once more → stuck[2]=0 the cycle rise is seen.
- Rise arriving exactly on win_cnt==WINDOW-1: counted in the closing window's freq_cnt; the next window does not double-count it.
- Reset pulsed mid-window (cycle 30 of 64): all outputs 0 immediately; next meas_valid 64 cycles after release; the first post-reset rise gives no period.
- Channels at periods 8, 12, 20, 300: periods 8/12/20 reported; period_3 saturates at 256 and stuck[3] toggles per edge gap.
- MINMAX_EN: periods alternating 10/14 → min=10, max=14; min_max_clr → min=all-ones, max=0 until the next measurement.
